// File: rtl/sim_clk_gen.sv
// Derived-clock generator: registered 50%-duty divided clock with edge strobes,
// a rising-edge counter and glitch-free run-time period reload. Option: SIM_CLK_LOCK_EN adds locked_o.
module sim_clk_gen #(
  parameter int T  = 8,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en_i,
  input  logic [PW-1:0] period_i,
  input  logic          period_ld_i,
  output logic          clk_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic [PW-1:0] cycle_cnt_o
`ifdef SIM_CLK_LOCK_EN
  ,
  output logic          locked_o
`endif
);

  localparam logic [PW-1:0] P_RST = PW'(T);
  localparam logic [PW-1:0] H_RST = PW'(T / 2);

  generate
    if (T < 2 || longint'(T) >= (longint'(1) << PW)) begin : g_bad_period
      $error("sim_clk_gen: T=%0d outside legal range 2..2^PW-1", T);
    end
  endgenerate

  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic [PW-1:0] h_q, h_d;
  logic [PW-1:0] shadow_q, shadow_d;
  logic          pend_q, pend_d;
  logic          clk_q, clk_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic [PW-1:0] cyc_q, cyc_d;
  logic          wrap;
  logic          apply;
  logic [PW-1:0] cap_val;

  // Reload only takes effect at wrap so the period in flight is never cut short.
  assign wrap    = en_i && (cnt_q == p_q - PW'(1));
  assign apply   = wrap && pend_q;
  assign cap_val = (period_i < PW'(2)) ? PW'(2) : period_i;

  always_comb begin
    cnt_d    = cnt_q;
    p_d      = p_q;
    h_d      = h_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    clk_d    = clk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    cyc_d    = cyc_q;

    if (en_i) begin
      cnt_d  = wrap ? '0 : cnt_q + PW'(1);
      clk_d  = (cnt_q < h_q);
      rise_d = (cnt_q == '0);
      fall_d = (cnt_q == h_q);
      if (rise_d) cyc_d = cyc_q + PW'(1);
    end

    if (apply) begin
      p_d = shadow_q;
      h_d = shadow_q >> 1;
    end

    // A load coinciding with an apply re-arms the flag for the following wrap.
    if (period_ld_i) begin
      shadow_d = cap_val;
      pend_d   = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      p_q      <= P_RST;
      h_q      <= H_RST;
      shadow_q <= P_RST;
      pend_q   <= 1'b0;
      clk_q    <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cyc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      h_q      <= h_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      clk_q    <= clk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cyc_q    <= cyc_d;
    end
  end

  assign clk_o       = clk_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign cycle_cnt_o = cyc_q;

`ifdef SIM_CLK_LOCK_EN
  logic locked_q, locked_d;

  always_comb begin
    locked_d = locked_q;
    if (wrap) locked_d = !apply;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) locked_q <= 1'b0;
    else       locked_q <= locked_d;
  end

  assign locked_o = locked_q;
`endif

endmodule

// File: tb/tb_sim_clk_gen.sv
// Scoreboard bench for sim_clk_gen: directed per-edge vectors pushed by the driver,
// popped and compared by an independent monitor just after each rising clk edge.
module tb_sim_clk_gen;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en_i = 1'b0;
  logic          period_ld_i = 1'b0;
  logic [PW-1:0] period_i = '0;
  logic          clk_o, rise_o, fall_o;
  logic [PW-1:0] cycle_cnt_o;
`ifdef SIM_CLK_LOCK_EN
  logic          locked_o;
`endif

  sim_clk_gen #(.T(8), .PW(PW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .en_i        (en_i),
    .period_i    (period_i),
    .period_ld_i (period_ld_i),
    .clk_o       (clk_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .cycle_cnt_o (cycle_cnt_o)
`ifdef SIM_CLK_LOCK_EN
    ,
    .locked_o    (locked_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    idx;
    logic  c;
    logic  r;
    logic  f;
    logic  l;
    int    cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_ok;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cyc = 0;

  function automatic logic bit_at(string s, int i);
    return s.getc(i) == 8'h31;
  endfunction

  // One edge per character; the strings hold the hand-derived clk/rise/fall/locked values.
  task automatic run(string name, logic en, int ld_at, int ld_val,
                     string c, string r, string f, string l);
    for (int i = 0; i < c.len(); i++) begin
      exp_t e;
      en_i        = en;
      period_ld_i = (i == ld_at);
      period_i    = PW'(ld_val);
      e.name = name;
      e.idx  = i;
      e.c    = bit_at(c, i);
      e.r    = bit_at(r, i);
      e.f    = bit_at(f, i);
      e.l    = bit_at(l, i);
      if (e.r) exp_cyc++;
      e.cyc = exp_cyc;
      sb.push_back(e);
      @(negedge clk);
    end
    period_ld_i = 1'b0;
  endtask

  task automatic check_rst(string name);
    logic ok;
    ok = (clk_o === 1'b0) && (rise_o === 1'b0) && (fall_o === 1'b0) && (cycle_cnt_o === '0);
`ifdef SIM_CLK_LOCK_EN
    ok = ok && (locked_o === 1'b0);
`endif
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: clk/rise/fall=%b%b%b cnt=%0d, required 000 cnt=0",
               name, clk_o, rise_o, fall_o, cycle_cnt_o);
    end else begin
      $display("[TB] %s ok", name);
    end
  endtask

  // Monitor: the DUT presents a registered output every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e  = sb.pop_front();
        mon_ok = (clk_o === mon_e.c) && (rise_o === mon_e.r) && (fall_o === mon_e.f) &&
                 (cycle_cnt_o === PW'(mon_e.cyc));
`ifdef SIM_CLK_LOCK_EN
        mon_ok = mon_ok && (locked_o === mon_e.l);
`endif
        n_tests++;
        if (!mon_ok) begin
          n_fail++;
          $display("FAIL %s[%0d]: clk/rise/fall/lock got %b%b%b cnt=%0d, want %b%b%b%b cnt=%0d",
                   mon_e.name, mon_e.idx, clk_o, rise_o, fall_o, cycle_cnt_o,
                   mon_e.c, mon_e.r, mon_e.f, mon_e.l, mon_e.cyc);
        end else begin
          $display("[TB] %s[%0d] ok clk=%b cnt=%0d", mon_e.name, mon_e.idx, clk_o, cycle_cnt_o);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check_rst("reset_state");
    rstn = 1'b1;

    // Default period 8: high edges 1-4, low 5-8; locked at first wrap (edge 8).
    run("A_T8", 1'b1, -1, 0, "1111000011110000", "1000000010000000",
        "0000100000001000", "0000000111111111");
    // Freeze for 3 edges in the high phase: level held, no strobes, period stretched by 3.
    run("B_pre", 1'b1, -1, 0, "11", "10", "00", "11");
    run("B_frz", 1'b0, -1, 0, "111", "000", "000", "111");
    run("B_res", 1'b1, -1, 0, "110000", "000000", "001000", "111111");
    // Load 5 mid-period: current 8-cycle period completes, then 1,1,0,0,0.
    run("C_ld5", 1'b1, 1, 5, "11110000", "10000000", "00001000", "11111110");
    run("C_p5", 1'b1, -1, 0, "1100011000", "1000010000", "0010000100", "0000111111");
    // Load 1 clamps to period 2; 10 edges give 5 rising edges.
    run("D_ld1", 1'b1, 1, 1, "11000", "10000", "00100", "11110");
    run("D_p2", 1'b1, -1, 0, "1010101010", "1010101010", "0101010101", "0111111111");
    // Load 6, then load 3 on the wrap edge: 6 applied there, 3 at the following wrap.
    run("D_a", 1'b1, 0, 6, "1", "1", "0", "1");
    run("D_b", 1'b1, 0, 3, "0", "0", "1", "0");
    run("D_p6", 1'b1, -1, 0, "111000", "100000", "000100", "000000");
    run("D_p3", 1'b1, -1, 0, "100100", "100100", "010010", "001111");
    // Leave a pending load of 5, then reset asynchronously in the high phase.
    run("E_pre", 1'b1, 0, 5, "1", "1", "0", "1");
    #2;
    rstn = 1'b0;
    #1;
    check_rst("async_reset_mid_high");
    @(negedge clk);
    rstn    = 1'b1;
    exp_cyc = 0;
    run("E_T8", 1'b1, -1, 0, "1111000011110000", "1000000010000000",
        "0000100000001000", "0000000111111111");

    repeat (3) if (sb.size() != 0) @(posedge clk);
    #2;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
